// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared types, constants and helpers for the 3x3 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Scanner state machine states
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } keypad_state_e;

    localparam logic [3:0] KEY_NONE = 4'd0;
    localparam int         NUM_ROWS = 3;
    localparam int         NUM_COLS = 3;

    // Key code for a zero-based (row, col): row*3 + col + 1, giving 1..9
    function automatic logic [3:0] keyCode(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    endfunction

    // Active-low one-hot row drive pattern for a zero-based row
    function automatic logic [NUM_ROWS-1:0] rowDrive(input logic [1:0] row);
        return ~(3'b001 << row);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module   : keypad_sync
// Brief    : Two-flop synchronizer for the asynchronous keypad column inputs.
//            Data flops carry no reset; they flush within two clocks.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_sync #(
    parameter int WIDTH = 3
) (
    input  logic             hwclk,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous columns
    always_ff @(posedge hwclk) begin
        r_meta <= i_async;
        r_sync <= r_meta;
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : Scans a 3x3 active-low matrix keypad, debounces the press and
//            release, and reports one clean key event per physical press
//            (button code, held state and a single-cycle strobe).
//            Optional macro KEYPAD_MULTI_REJECT_EN: when defined, a row with
//            two or more low columns is treated as no key; otherwise the
//            lowest-numbered low column wins.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1200,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       hwclk,
    input  logic       resetN,
    output logic       keypad_r1,
    output logic       keypad_r2,
    output logic       keypad_r3,
    input  logic       keypad_c1,
    input  logic       keypad_c2,
    input  logic       keypad_c3,
    output logic [3:0] button,
    output logic       bstate,
    output logic       key_strobe
);

    localparam int c_SLOT_W = $clog2(SCAN_CYCLES);
    localparam int c_CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_ONE  = c_SLOT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_DEB_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_DEB_MAX   = c_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_ST_SCAN     = SCAN;
    localparam logic [1:0] c_ST_DEBOUNCE = DEBOUNCE;
    localparam logic [1:0] c_ST_PRESSED  = PRESSED;
    localparam logic [1:0] c_ST_RELEASE  = RELEASE;

    logic [NUM_COLS-1:0] w_colsAsync;
    logic [NUM_COLS-1:0] w_cols;          // synchronized, active-low

    logic [1:0]          r_state;
    logic [1:0]          r_row;
    logic [NUM_ROWS-1:0] r_rows;          // 111 only straight after reset
    logic [c_SLOT_W-1:0] r_slotCnt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [1:0]          r_candCol;
    logic [NUM_COLS-1:0] r_candPat;
    logic [3:0]          r_button;
    logic                r_bstate;
    logic                r_strobe;

    logic [1:0]          w_rowNext;
    logic [c_CNT_W-1:0]  w_cntInc;
    logic                w_anyLow;
    logic                w_hit;
    logic [1:0]          w_hitCol;
    logic                w_candHigh;

    assign w_colsAsync = {keypad_c3, keypad_c2, keypad_c1};

    keypad_sync #(
        .WIDTH (NUM_COLS)
    ) u_sync (
        .hwclk   (hwclk),
        .i_async (w_colsAsync),
        .o_sync  (w_cols)
    );

    assign w_rowNext  = (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
    assign w_cntInc   = (r_cnt == c_DEB_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
    assign w_anyLow   = ~&w_cols;
    assign w_candHigh = w_cols[r_candCol];

`ifdef KEYPAD_MULTI_REJECT_EN
    assign w_hit = w_anyLow && ($countones(~w_cols) == 1);
`else
    assign w_hit = w_anyLow;
`endif

    // Lowest-numbered low column wins (c1 over c2 over c3)
    always_comb begin
        w_hitCol = 2'd0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!w_cols[i]) begin
                w_hitCol = 2'(i);
            end
        end
    end

    // Scan / debounce / press / release sequencing and registered outputs
    always_ff @(posedge hwclk) begin
        if (!resetN) begin
            r_state   <= c_ST_SCAN;
            r_row     <= 2'd0;
            r_rows    <= '1;
            r_slotCnt <= '0;
            r_cnt     <= '0;
            r_candCol <= 2'd0;
            r_candPat <= '1;
            r_button  <= KEY_NONE;
            r_bstate  <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                c_ST_SCAN: begin
                    if (r_rows == '1) begin
                        // First clock out of reset: start driving row 0
                        r_rows    <= rowDrive(r_row);
                        r_slotCnt <= '0;
                    end else if (r_slotCnt == c_SLOT_LAST) begin
                        r_slotCnt <= '0;
                        if (w_hit) begin
                            r_state   <= c_ST_DEBOUNCE;
                            r_candCol <= w_hitCol;
                            r_candPat <= w_cols;
                            r_cnt     <= '0;
                        end else begin
                            r_row  <= w_rowNext;
                            r_rows <= rowDrive(w_rowNext);
                        end
                    end else begin
                        r_slotCnt <= r_slotCnt + c_SLOT_ONE;
                    end
                end
                c_ST_DEBOUNCE: begin
                    if (w_cols != r_candPat) begin
                        // Pattern changed: give up and move on to the next row
                        r_state   <= c_ST_SCAN;
                        r_cnt     <= '0;
                        r_slotCnt <= '0;
                        r_row     <= w_rowNext;
                        r_rows    <= rowDrive(w_rowNext);
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_state  <= c_ST_PRESSED;
                        r_cnt    <= '0;
                        r_button <= keyCode(r_row, r_candCol);
                        r_bstate <= 1'b1;
                        r_strobe <= 1'b1;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
                c_ST_PRESSED: begin
                    if (w_candHigh) begin
                        r_state <= c_ST_RELEASE;
                        r_cnt   <= '0;
                    end
                end
                c_ST_RELEASE: begin
                    if (!w_candHigh) begin
                        r_state <= c_ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_state   <= c_ST_SCAN;
                        r_cnt     <= '0;
                        r_bstate  <= 1'b0;
                        r_row     <= 2'd0;
                        r_rows    <= rowDrive(2'd0);
                        r_slotCnt <= '0;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
                default: begin
                    r_state <= c_ST_SCAN;
                end
            endcase
        end
    end

    assign keypad_r1  = r_rows[0];
    assign keypad_r2  = r_rows[1];
    assign keypad_r3  = r_rows[2];
    assign button     = r_button;
    assign bstate     = r_bstate;
    assign key_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Scoreboard bench for keypad_scanner. A keypad model turns the
//            row drives and a per-period "held" waveform into column levels;
//            a slot-timeline reference model predicts row patterns, strobes
//            and releases, which a monitor compares against the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SC     = 8;
    localparam int DC     = 16;
    localparam int c_WAVE = 512;
`ifdef KEYPAD_MULTI_REJECT_EN
    localparam bit c_REJECT = 1'b1;
`else
    localparam bit c_REJECT = 1'b0;
`endif

    logic       hwclk  = 1'b0;
    logic       resetN = 1'b0;
    logic       keypad_r1, keypad_r2, keypad_r3;
    logic       keypad_c1, keypad_c2, keypad_c3;
    logic [3:0] button;
    logic       bstate;
    logic       key_strobe;

    // Physical keypad: pressed keys sit in keyRow at the columns of keyCols
    logic       pressed = 1'b0;
    int         keyRow  = 0;
    logic [2:0] keyCols = 3'b000;
    logic [2:0] rowsv;

    always #5 hwclk = ~hwclk;

    always_comb begin
        rowsv     = {keypad_r3, keypad_r2, keypad_r1};
        keypad_c1 = !(pressed && keyCols[0] && !rowsv[keyRow]);
        keypad_c2 = !(pressed && keyCols[1] && !rowsv[keyRow]);
        keypad_c3 = !(pressed && keyCols[2] && !rowsv[keyRow]);
    end

    keypad_scanner #(
        .SCAN_CYCLES     (SC),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .hwclk      (hwclk),
        .resetN     (resetN),
        .keypad_r1  (keypad_r1),
        .keypad_r2  (keypad_r2),
        .keypad_r3  (keypad_r3),
        .keypad_c1  (keypad_c1),
        .keypad_c2  (keypad_c2),
        .keypad_c3  (keypad_c3),
        .button     (button),
        .bstate     (bstate),
        .key_strobe (key_strobe)
    );

    typedef struct { int p; logic [2:0] rows; } rowChk_t;
    typedef struct { int p; logic [3:0] code; } ev_t;

    rowChk_t rowsQ[$];
    ev_t     strobeQ[$];
    ev_t     fallQ[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   rstS   = 1'b0;
    logic prevB  = 1'b0;

    logic heldA [0:c_WAVE-1];
    int   baseP   = 0;
    int   waveEnd = 0;

    // Period counter: period n is the interval following clock edge n
    always @(posedge hwclk) begin
        cyc  = cyc + 1;
        rstS = resetN;
    end

    function automatic bit heldAt(input int p);
        if (p < baseP || p >= baseP + c_WAVE) return 1'b0;
        return heldA[p - baseP];
    endfunction

    function automatic logic [2:0] rowPat(input int r);
        logic [2:0] v;
        v    = 3'b111;
        v[r] = 1'b0;
        return v;
    endfunction

    // Slot-timeline reference: slots of SC periods, columns seen 2 periods late
    task automatic model(input int kRow, input logic [3:0] code, input bit multi,
                         input bit stopAtStrobe, output int strobeP, output int endP);
        int p, r, t, q, v0, v1, limit, f;
        p       = baseP;
        r       = 0;
        strobeP = -1;
        limit   = baseP + waveEnd + 50;
        while (p < limit) begin
            rowsQ.push_back('{p, rowPat(r)});
            rowsQ.push_back('{p + SC - 1, rowPat(r)});
            t = p + SC - 1;
            if (r == kRow && heldAt(t - 2) && !(c_REJECT && multi)) begin
                q = -1;
                for (int x = t - 1; x <= t + DC - 2; x++) begin
                    if (!heldAt(x)) begin q = x; break; end
                end
                if (q >= 0) begin
                    p = q + 3;
                    r = (r + 1) % 3;
                end else begin
                    strobeP = t + DC + 1;
                    strobeQ.push_back('{strobeP, code});
                    if (stopAtStrobe) begin
                        endP = strobeP;
                        return;
                    end
                    v0 = t + DC - 1;
                    forever begin
                        while (heldAt(v0)) v0++;
                        v1 = -1;
                        for (int x = v0 + 1; x <= v0 + DC; x++) begin
                            if (heldAt(x)) begin v1 = x; break; end
                        end
                        if (v1 < 0) break;
                        v0 = v1 + 1;
                    end
                    f = v0 + DC + 3;
                    fallQ.push_back('{f, code});
                    p = f;
                    r = 0;
                end
            end else begin
                p = p + SC;
                r = (r + 1) % 3;
            end
        end
        endP = p;
    endtask

    // Output monitor: reset values, queued row checks, strobe and release events
    always @(negedge hwclk) begin
        if (!rstS) begin
            checks++;
            if (rowsv !== 3'b111 || button !== 4'd0 || bstate !== 1'b0 || key_strobe !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d rows=%b button=%0d bstate=%b strobe=%b required 111/0/0/0",
                         cyc, rowsv, button, bstate, key_strobe);
            end
        end
        if (rowsQ.size() > 0 && rowsQ[0].p == cyc) begin
            checks++;
            if (rowsv !== rowsQ[0].rows) begin
                errors++;
                $display("FAIL row_scan cyc=%0d rows=%b required %b", cyc, rowsv, rowsQ[0].rows);
            end
            void'(rowsQ.pop_front());
        end
        if (key_strobe === 1'b1) begin
            checks++;
            if (strobeQ.size() == 0 || strobeQ[0].p != cyc) begin
                errors++;
                $display("FAIL strobe_time cyc=%0d unexpected strobe, next required at %0d",
                         cyc, (strobeQ.size() > 0) ? strobeQ[0].p : -1);
            end else begin
                if (button !== strobeQ[0].code || bstate !== 1'b1 || prevB !== 1'b0) begin
                    errors++;
                    $display("FAIL strobe_value cyc=%0d button=%0d bstate=%b prev=%b required %0d/1/0",
                             cyc, button, bstate, prevB, strobeQ[0].code);
                end
                void'(strobeQ.pop_front());
            end
        end else if (strobeQ.size() > 0 && strobeQ[0].p == cyc) begin
            checks++;
            errors++;
            $display("FAIL strobe_missing cyc=%0d strobe=0 required 1 (button %0d)", cyc, strobeQ[0].code);
            void'(strobeQ.pop_front());
        end
        if (rstS && prevB === 1'b1 && bstate === 1'b0) begin
            checks++;
            if (fallQ.size() == 0 || fallQ[0].p != cyc) begin
                errors++;
                $display("FAIL release_time cyc=%0d unexpected bstate fall, next required at %0d",
                         cyc, (fallQ.size() > 0) ? fallQ[0].p : -1);
            end else begin
                if (button !== fallQ[0].code) begin
                    errors++;
                    $display("FAIL release_button cyc=%0d button=%0d required %0d", cyc, button, fallQ[0].code);
                end
                void'(fallQ.pop_front());
            end
        end else if (fallQ.size() > 0 && fallQ[0].p == cyc) begin
            checks++;
            errors++;
            $display("FAIL release_missing cyc=%0d bstate=%b required fall", cyc, bstate);
            void'(fallQ.pop_front());
        end
        prevB = bstate;
    end

    // One reset-started trial: build waveform, predict, drive, confirm drained
    task automatic runTrial(input int kind, input int kRow, input logic [2:0] cols,
                            input int idle, input int hold);
        int         lc, sP, eP;
        logic [3:0] code;
        bit         multi;
        for (int i = 0; i < c_WAVE; i++) heldA[i] = 1'b0;
        if (kind == 2) begin
            for (int i = 0; i < 60; i++) heldA[idle + i] = ((i / 5) % 2 == 0);
            for (int i = 60; i < 60 + hold; i++) heldA[idle + i] = 1'b1;
            waveEnd = idle + 60 + hold;
        end else begin
            for (int i = idle; i < idle + hold; i++) heldA[i] = 1'b1;
            waveEnd = idle + hold;
        end
        lc = 0;
        for (int j = 2; j >= 0; j--) if (cols[j]) lc = j;
        code  = 4'(kRow * 3 + lc + 1);
        multi = ($countones(cols) > 1);

        @(posedge hwclk); #1;
        resetN  = 1'b0;
        pressed = 1'b0;
        keyRow  = kRow;
        keyCols = cols;
        repeat (3) @(posedge hwclk);
        #1;
        resetN = 1'b1;
        baseP  = cyc + 1;
        model(kRow, code, multi, (kind == 4), sP, eP);

        if (kind == 4 && sP >= 0) begin
            while (cyc < sP + 3) begin
                @(posedge hwclk); #1;
                pressed = heldAt(cyc);
            end
            resetN  = 1'b0;
            pressed = 1'b0;
            @(posedge hwclk); #1;
            resetN = 1'b1;
            baseP  = cyc + 1;
            for (int i = 0; i < c_WAVE; i++) heldA[i] = 1'b0;
            waveEnd = 0;
            model(kRow, code, multi, 1'b0, sP, eP);
        end
        while (cyc < eP + 3) begin
            @(posedge hwclk); #1;
            pressed = heldAt(cyc);
        end
        pressed = 1'b0;

        checks++;
        if (strobeQ.size() != 0 || fallQ.size() != 0 || rowsQ.size() != 0) begin
            errors++;
            $display("FAIL trial_drain kind=%0d pending strobe=%0d release=%0d rows=%0d required 0/0/0",
                     kind, strobeQ.size(), fallQ.size(), rowsQ.size());
            strobeQ.delete();
            fallQ.delete();
            rowsQ.delete();
        end
    endtask

    initial begin
        int         kind, row, idle, hold;
        logic [2:0] cols;
        logic [2:0] pairs [3];
        pairs[0] = 3'b011;
        pairs[1] = 3'b101;
        pairs[2] = 3'b110;

        runTrial(0, 1, 3'b010, 5, 100);   // key 5 clean press and release
        runTrial(2, 1, 3'b010, 3, 50);    // key 5 with c2 bouncing
        runTrial(1, 2, 3'b100, 18, 14);   // key 9 glitch during debounce
        runTrial(3, 1, 3'b101, 4, 80);    // keys 4 and 6 together
        runTrial(4, 0, 3'b001, 6, 200);   // reset while key 1 is pressed

        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 4));
            row  = int'($urandom_range(0, 2));
            idle = int'($urandom_range(0, 40));
            if (kind == 3) cols = pairs[$urandom_range(0, 2)];
            else           cols = 3'b001 << $urandom_range(0, 2);
            case (kind)
                0:       hold = int'($urandom_range(30, 120));
                1:       hold = int'($urandom_range(1, 25));
                2:       hold = int'($urandom_range(30, 60));
                3:       hold = int'($urandom_range(40, 80));
                default: hold = 200;
            endcase
            runTrial(kind, row, cols, idle, hold);
        end

        repeat (4) @(posedge hwclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
